// File: rtl/cmsdk_apb_slave_mux_tmo.sv
// cmsdk_apb_slave_mux_tmo: APB response mux with wait-state timeout, unmapped/multi-select errors and sticky status
module cmsdk_apb_slave_mux_tmo #(
  parameter int NUM_SLAVES     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int UNMAP_SLVERR   = 1,
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic                             psel,
  input  logic                             penable,
  input  logic [NUM_SLAVES-1:0]            pselx,
  input  logic [NUM_SLAVES-1:0]            preadyx,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdatax,
  input  logic [NUM_SLAVES-1:0]            pslverrx,
  output logic                             pready,
  output logic [DATA_WIDTH-1:0]            prdata,
  output logic                             pslverr,
  input  logic                             tout_clr,
  output logic                             tout_flag,
  output logic [IW-1:0]                    tout_idx,
  output logic                             msel_flag,
  output logic                             tout_irq
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, TOUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [IW-1:0] idx, idx_q, idx_d;
  logic onehot, multi, rdy, err, tout, force_rsp;
  logic [DATA_WIDTH-1:0] dat;
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (pselx[i]) idx = IW'(i);
  end
  assign onehot = pselx != '0 && (pselx & (pselx - NUM_SLAVES'(1))) == '0;
  assign multi  = pselx != '0 && !onehot;
  assign rdy    = preadyx[idx];
  assign err    = pslverrx[idx];
  assign dat    = prdatax[idx*DATA_WIDTH +: DATA_WIDTH];
  assign tout   = state_q == TOUT;
  // The wait counter only runs while the same single slave stays selected and stalled
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (TIMEOUT_CYCLES != 0 && psel && penable && onehot && !rdy) begin
        state_d = WAIT;
        cnt_d   = CW'(1);
        sel_d   = pselx;
        idx_d   = idx;
      end
      WAIT: if (!psel || pselx != sel_q || rdy) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == TLAST ? TOUT : WAIT;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
    end
  end
  assign force_rsp = preset || tout || !onehot;
  assign pready    = force_rsp ? 1'b1 : rdy;
  assign prdata    = force_rsp ? '0 : dat;
  assign pslverr   = preset ? 1'b0 : tout ? 1'b1 : onehot ? err & rdy :
                     multi ? penable : psel & penable & (UNMAP_SLVERR != 0);
  // Setting a flag takes priority over a simultaneous clear
  always_ff @(posedge pclk) begin
    if (preset) begin
      tout_flag <= 1'b0;
      tout_idx  <= '0;
      msel_flag <= 1'b0;
    end else begin
      tout_flag <= tout | (tout_flag & !tout_clr);
      tout_idx  <= tout ? idx_q : tout_clr ? '0 : tout_idx;
      msel_flag <= (psel & penable & multi) | (msel_flag & !tout_clr);
    end
  end
  assign tout_irq = tout_flag | msel_flag;
endmodule
